// File: rtl/hazard_scoreboard.sv
// Hazard unit beside the D stage: tracks in-flight destinations and their time-to-result,
// raises the PC/D stall and E bubble, selects per-operand forwarding, and owns the mult/div busy counter.
module hazard_scoreboard #(
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned TW       = 4,
  parameter int unsigned RW       = 5,
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned SW       = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] d_needreg1,
  input  logic [RW-1:0] d_needreg2,
  input  logic [TW-1:0] d_tuse1,
  input  logic [TW-1:0] d_tuse2,
  input  logic [RW-1:0] d_writereg,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          d_md_use,
  input  logic          flush,
  output logic          stall,
  output logic          bubble_e,
  output logic          md_busy,
  output logic [SW-1:0] fwd_sel1,
  output logic [SW-1:0] fwd_sel2
);

  localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  // Forwarding select must be able to name every slot plus the register file.
  if ((2 ** SW) < (NSTAGE + 1)) begin : g_sw_check
    $error("hazard_scoreboard: SW too narrow for NSTAGE");
  end

  typedef struct packed {
    logic [RW-1:0] writereg;
    logic [TW-1:0] tnew;
  } slot_t;

  slot_t         slots [NSTAGE];
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          data_stall;
  logic          md_stall;
  logic          found1;
  logic          found2;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Data hazard: a producer anywhere in flight whose result arrives after the operand is needed.
  always_comb begin
    data_stall = 1'b0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      if (slots[i].writereg != '0) begin
        if ((slots[i].writereg == d_needreg1) && (d_tuse1 < slots[i].tnew)) begin
          data_stall = 1'b1;
        end
        if ((slots[i].writereg == d_needreg2) && (d_tuse2 < slots[i].tnew)) begin
          data_stall = 1'b1;
        end
      end
    end
  end

  always_comb begin
    md_stall = d_md_use && (cnt != '0);
    stall    = data_stall || md_stall;
    bubble_e = stall;
  end

  // Forward only from the nearest producer; an older match holds a stale value.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    found1   = 1'b0;
    found2   = 1'b0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      if (!found1 && (slots[i].writereg != '0) && (slots[i].writereg == d_needreg1)) begin
        found1 = 1'b1;
        if (slots[i].tnew == '0) begin
          fwd_sel1 = SW'(i + 1);
        end
      end
      if (!found2 && (slots[i].writereg != '0) && (slots[i].writereg == d_needreg2)) begin
        found2 = 1'b1;
        if (slots[i].tnew == '0) begin
          fwd_sel2 = SW'(i + 1);
        end
      end
    end
  end

  // Busy counter loads only when the mult/div actually leaves D.
  always_comb begin
    cnt_nxt = cnt;
    if (d_md_start && !stall) begin
      cnt_nxt = d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NSTAGE; i++) begin
        slots[i] <= '0;
      end
      cnt     <= '0;
      md_busy <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      md_busy <= (cnt_nxt != '0);
      if (flush) begin
        for (int unsigned i = 0; i < NSTAGE; i++) begin
          slots[i] <= '0;
        end
      end else begin
        for (int unsigned i = 1; i < NSTAGE; i++) begin
          slots[i].writereg <= slots[i-1].writereg;
          slots[i].tnew     <= sat_dec(slots[i-1].tnew);
        end
        if (stall) begin
          slots[0] <= '0;
        end else begin
          slots[0].writereg <= d_writereg;
          slots[0].tnew     <= d_tnew;
        end
      end
    end
  end

endmodule
